// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
//   Digit-serial packed-BCD subtractor producing |A - B| and a sign flag,
//   one BCD digit per clock, least-significant digit first. A negative raw
//   result is turned into its magnitude by a second digit-serial
//   ten's-complement pass.
//
// Ports
//   CLK     : clock, rising edge
//   RST     : synchronous active-high reset
//   START   : request, sampled only while idle
//   A, B    : minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   BUSY    : high from the accepting edge until the edge that raises DONE
//   DONE    : one-cycle pulse, result valid
//   D       : magnitude |A - B|, packed BCD
//   NEG     : 1 when A < B
//   INVALID : 1 when any digit of A or B was > 9 at accept
module bcd_serial_subtractor #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   D,
  output logic                  NEG,
  output logic                  INVALID
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SUB, COMP, FIN} state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  r_reg;
  logic [IW-1:0] idx;
  logic          borrow;
  logic          neg_reg;
  logic          inv_reg;

  logic [3:0]    m_dig;
  logic [3:0]    s_dig;
  logic [4:0]    t;
  logic          b_out;
  logic [3:0]    d_dig;
  logic          bad_in;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign bad_in = has_bad_digit(A) | has_bad_digit(B);

  // Shared digit datapath: SUB computes a[i]-b[i]-borrow, COMP reuses it as
  // 0-r[i]-borrow over the stored raw digits to form the ten's complement.
  always_comb begin
    m_dig = '0;
    s_dig = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        m_dig = (state == SUB) ? a_reg[4*k +: 4] : 4'd0;
        s_dig = (state == SUB) ? b_reg[4*k +: 4] : r_reg[4*k +: 4];
      end
    end
    t     = {1'b0, m_dig} - {1'b0, s_dig} - {4'b0000, borrow};
    b_out = t[4];
    d_dig = b_out ? 4'(t + 5'd10) : t[3:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      D       <= '0;
      NEG     <= 1'b0;
      INVALID <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      r_reg   <= '0;
      idx     <= '0;
      borrow  <= 1'b0;
      neg_reg <= 1'b0;
      inv_reg <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_reg   <= A;
            b_reg   <= B;
            r_reg   <= '0;
            BUSY    <= 1'b1;
            idx     <= '0;
            borrow  <= 1'b0;
            neg_reg <= 1'b0;
            inv_reg <= bad_in;
            state   <= bad_in ? FIN : SUB;
          end
        end
        SUB, COMP: begin
          for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) r_reg[4*k +: 4] <= d_dig;
          end
          if (idx == LAST) begin
            idx    <= '0;
            borrow <= 1'b0;
            if (state == SUB) begin
              neg_reg <= b_out;
              state   <= b_out ? COMP : FIN;
            end else begin
              state <= FIN;
            end
          end else begin
            idx    <= idx + 1'b1;
            borrow <= b_out;
          end
        end
        FIN: begin
          D       <= inv_reg ? '0 : r_reg;
          NEG     <= neg_reg & ~inv_reg;
          INVALID <= inv_reg;
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LIMIT  = 3 * DIGITS + 10;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] D;
  logic         NEG;
  logic         INVALID;

  int total = 0;
  int bad   = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .D(D), .NEG(NEG), .INVALID(INVALID)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model (integer arithmetic) ----------------
  function automatic bit any_bad(input logic [W-1:0] v);
    bit r = 0;
    for (int k = 0; k < DIGITS; k++) if (v[4*k +: 4] > 4'd9) r = 1;
    return r;
  endfunction

  function automatic int bcd_val(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int x);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] ed, output logic en,
                       output logic ei, output int elat);
    int diff;
    if (any_bad(a) || any_bad(b)) begin
      ed = '0; en = 0; ei = 1; elat = 1;
    end else begin
      diff = bcd_val(a) - bcd_val(b);
      en   = (diff < 0);
      ed   = to_bcd(en ? -diff : diff);
      ei   = 0;
      elat = en ? 2 * DIGITS + 1 : DIGITS + 1;
    end
  endtask

  // Issues one operation, scrambles operands after accept, and reports the
  // accept-to-DONE edge count and the number of cycles BUSY was seen high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt);
    @(negedge CLK);
    A = a; B = b; START = 1;
    @(posedge CLK);
    @(negedge CLK);
    START = 0;
    A = W'($urandom);
    B = W'($urandom);
    busy_cnt = BUSY ? 1 : 0;
    lat = -1;
    for (int e = 1; e <= LIMIT; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE) begin lat = e; break; end
      if (BUSY) busy_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1; START = 0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({BUSY, DONE, NEG, INVALID} !== 4'b0000 || D !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b neg=%b inv=%b d=%h, want all 0",
               BUSY, DONE, NEG, INVALID, D);
    end
    RST = 0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [9] = '{16'h0042, 16'h0017, 16'h0000, 16'h5000, 16'h1000,
                             16'h00A1, 16'h0003, 16'h9999, 16'h0100};
    logic [W-1:0] tb [9] = '{16'h0017, 16'h0042, 16'h9999, 16'h5000, 16'h0001,
                             16'h0003, 16'h000F, 16'h0000, 16'h0250};
    logic [W-1:0] td [9] = '{16'h0025, 16'h0025, 16'h9999, 16'h0000, 16'h0999,
                             16'h0000, 16'h0000, 16'h9999, 16'h0150};
    logic tn [9] = '{0, 1, 1, 0, 0, 0, 0, 0, 1};
    logic ti [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    int   tl [9] = '{5, 9, 9, 5, 5, 1, 1, 5, 9};
    int lat, bc;
    for (int i = 0; i < 9; i++) begin
      do_op(ta[i], tb[i], lat, bc);
      total++;
      if (lat !== tl[i]) begin
        bad++;
        $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, tl[i]);
      end
      total++;
      if (bc !== tl[i] || BUSY !== 1'b0) begin
        bad++;
        $display("FAIL directed[%0d] busy: cycles %0d busy_at_done %b want %0d,0",
                 i, bc, BUSY, tl[i]);
      end
      total++;
      if (D !== td[i] || NEG !== tn[i] || INVALID !== ti[i]) begin
        bad++;
        $display("FAIL directed[%0d] result: d=%h neg=%b inv=%b want d=%h neg=%b inv=%b",
                 i, D, NEG, INVALID, td[i], tn[i], ti[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    int extra = 0;
    @(negedge CLK);
    A = 16'h0017; B = 16'h0042; START = 1;
    @(posedge CLK);
    @(negedge CLK);
    START = 0;
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    A = 16'h9999; B = 16'h0000; START = 1;
    @(posedge CLK);
    @(negedge CLK);
    START = 0; A = 16'h1234; B = 16'h0001;
    for (int e = 4; e <= LIMIT; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE) begin lat = e; break; end
    end
    total++;
    if (lat !== 9 || D !== 16'h0025 || NEG !== 1'b1) begin
      bad++;
      $display("FAIL busy_ignore: lat=%0d d=%h neg=%b want 9 0025 1", lat, D, NEG);
    end
    repeat (12) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE || BUSY) extra++;
    end
    total++;
    if (extra !== 0 || D !== 16'h0025) begin
      bad++;
      $display("FAIL busy_ignore_idle: activity=%0d d=%h want 0 0025", extra, D);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1;
    int lat2 = -1;
    @(negedge CLK);
    A = 16'h0042; B = 16'h0017; START = 1;
    @(posedge CLK);
    for (int e = 1; e <= LIMIT; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE) begin lat1 = e; break; end
    end
    total++;
    if (lat1 !== 5 || D !== 16'h0025 || NEG !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: lat=%0d d=%h neg=%b want 5 0025 0", lat1, D, NEG);
    end
    A = 16'h0100; B = 16'h0250;
    @(posedge CLK);
    @(negedge CLK);
    START = 0;
    total++;
    if (BUSY !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b want 1", BUSY);
    end
    for (int e = 1; e <= LIMIT; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE) begin lat2 = e; break; end
    end
    total++;
    if (lat2 !== 9 || D !== 16'h0150 || NEG !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d d=%h neg=%b want 9 0150 1", lat2, D, NEG);
    end
  endtask

  task automatic test_reset_abort();
    int extra = 0;
    int lat, bc;
    @(negedge CLK);
    A = 16'h0017; B = 16'h0042; START = 1;
    @(posedge CLK);
    @(negedge CLK);
    START = 0;
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    RST = 1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    total++;
    if ({BUSY, DONE, NEG, INVALID} !== 4'b0000 || D !== '0) begin
      bad++;
      $display("FAIL reset_abort: busy=%b done=%b neg=%b inv=%b d=%h want all 0",
               BUSY, DONE, NEG, INVALID, D);
    end
    repeat (12) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE || BUSY) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL reset_abort_quiet: activity=%0d want 0", extra);
    end
    do_op(16'h0042, 16'h0017, lat, bc);
    total++;
    if (lat !== 5 || D !== 16'h0025 || NEG !== 1'b0 || INVALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort_after: lat=%0d d=%h neg=%b inv=%b want 5 0025 0 0",
               lat, D, NEG, INVALID);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, ed;
    logic en, ei;
    int elat, lat, bc;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < DIGITS; k++) begin
        a[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
        b[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 5) == 0) b = a;
      model(a, b, ed, en, ei, elat);
      do_op(a, b, lat, bc);
      total++;
      if (lat !== elat || bc !== elat) begin
        bad++;
        $display("FAIL random[%0d] timing a=%h b=%h: lat=%0d busy=%0d want %0d",
                 i, a, b, lat, bc, elat);
      end
      total++;
      if (D !== ed || NEG !== en || INVALID !== ei) begin
        bad++;
        $display("FAIL random[%0d] result a=%h b=%h: d=%h neg=%b inv=%b want d=%h neg=%b inv=%b",
                 i, a, b, D, NEG, INVALID, ed, en, ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bcd_serial_subtractor.md
Name: bcd_serial_subtractor

Overview:
- Digit-serial, multi-digit packed-BCD subtractor. It is the subtract-direction counterpart of the ALU's BCD add path.
- Computes |A − B| as packed BCD plus a sign flag, processing one BCD digit per clock, least-significant digit first.
- A negative raw result is corrected by a second digit-serial ten's-complement pass.
- Sits in the ALU datapath beside the BCD adder chain and is started by the ALU control FSM through a START/DONE handshake.

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..8.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- A  input  4*DIGITS  minuend, packed BCD; digit 0 is in bits [3:0].
- B  input  4*DIGITS  subtrahend, packed BCD.
- BUSY  output  1  high from the accepting edge until the edge that raises DONE.
- DONE  output  1  one-cycle pulse; result valid.
- D  output  4*DIGITS  magnitude |A − B|, packed BCD.
- NEG  output  1  1 when A < B.
- INVALID  output  1  1 when any digit of A or B was > 9 at accept.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST).
- Reset: state IDLE; BUSY, DONE, NEG and INVALID are 0; D is 0; internal borrow and digit index are 0. RST asserted mid-operation aborts the operation: no DONE, and the outputs above are cleared on that edge.
- States: IDLE, SUB, COMP, FIN.
- IDLE: at an edge with START=1, latch A and B into internal registers, set BUSY=1, and check every digit.
  - If any digit is > 9: go to FIN with the invalid flag set.
  - Otherwise: go to SUB with index=0 and borrow=0.
- SUB: one digit per edge.
  - Compute t = a[i] − b[i] − borrow, as a 5-bit signed value.
  - If t < 0: store t+10 and set borrow=1. Otherwise store t and set borrow=0.
  - Increment index.
  - After digit DIGITS−1: if the final borrow is 0, go to FIN; if it is 1, go to COMP with index=0 and borrow=0.
- COMP: same datapath with minuend 0 and subtrahend equal to the stored raw digit, so digit = (0 − r[i] − borrow) with the same +10 correction. This produces the ten's complement of the raw result. After digit DIGITS−1, go to FIN; the final borrow is discarded.
- FIN: at one edge:
  - register D (0 if invalid), NEG (= SUB final borrow; 0 if invalid) and INVALID;
  - raise DONE=1 and set BUSY=0;
  - go to IDLE.
- DONE drops at the next edge.
- D, NEG and INVALID hold until the next FIN or RST.
- Latency, counting the accept edge as edge 0, to the edge that raises DONE:
  - valid and A ≥ B: DIGITS+1 edges;
  - valid and A < B: 2*DIGITS+1 edges;
  - invalid: 1 edge.
- START is ignored while BUSY=1. START=1 in the same cycle DONE is high is accepted, because the FSM is already in IDLE.
- Changes on A or B after the accept edge have no effect.
- A = B gives D=0 and NEG=0, and never negative zero.
- No digit of D is ever > 9.

Test Plan:
- DIGITS=4, A=0x0042, B=0x0017, START pulse -> DONE 5 edges after accept; D=0x0025, NEG=0, INVALID=0; BUSY high for exactly the 5 intervening cycles.
- A=0x0017, B=0x0042 -> DONE 9 edges after accept; D=0x0025, NEG=1. Also A=0x0000, B=0x9999 -> D=0x9999, NEG=1.
- A=0x5000, B=0x5000 -> D=0x0000, NEG=0. Also A=0x1000, B=0x0001 -> D=0x0999, exercising borrow ripple through all digits.
- A=0x00A1, B=0x0003 -> DONE 1 edge after accept; INVALID=1, D=0, NEG=0. The next valid operation clears INVALID.
- Second START pulse and operand change during BUSY -> ignored, and the first result is unchanged. START held high through DONE -> back-to-back operation accepted with no idle gap.
- RST asserted at edge 3 of a negative operation -> no DONE; BUSY, D, NEG and INVALID are 0 on the next cycle. A following START completes normally.
